epochtv1_olb: RTL and testbench
===============================

Name: epochtv1_olb

Overview:
Parametrised object line buffer (OLB) for the TV-1 sprite path, generalising the fixed 8-pixel, 2-row OLB. The sprite drawer writes opaque pattern segments at arbitrary X into the back bank while the video side streams pixels from the front bank, which clears as it is read. It adds a selectable priority mode, a per-line object limit with an overflow flag, and optional X wrap-around.

Parameters:
LINE_W, 256, pixels per line; power of 2, multiple of SEG_W
SEG_W, 8, pixels per memory word and per write segment; power of 2
CLR_W, 4, colour index width
MAX_OBJ, 0, max objects accepted per line; 0 means unlimited
WRAP, 0, 1 means segments crossing LINE_W-1 wrap to X=0; 0 means the excess pixels are dropped
PRIO_FIRST, 1, 1 means the first opaque writer wins (read-modify-write); 0 means the last writer wins

Ports:
CLK  in  1  clock (XTAL*2)
RESB  in  1  async active-low reset
CE  in  1  pixel clock enable; all state advances only when CE=1
LINE_START  in  1  swap banks; front becomes back and vice versa
OBJ_START  in  1  first segment of a new object (qualified with WR_VALID)
WR_VALID  in  1  segment request
WR_READY  out  1  segment accepted this CE
WR_X  in  log2(LINE_W)  X of pattern bit SEG_W-1
WR_PAT  in  SEG_W  opacity mask, MSB leftmost
WR_CLR  in  CLR_W  colour for the segment
RD_EN  in  1  read pixel RD_X from the front bank
RD_X  in  log2(LINE_W)  read column
PX_OPQ  out  1  pixel opaque
PX_CLR  out  CLR_W  pixel colour (0 when PX_OPQ=0)
OVF  out  1  object limit exceeded on the current back line
BANK  out  1  index of the current back (write) bank

Behaviour:
- Reset (async, RESB=0): BANK=0, OVF=0, PX_OPQ=0, PX_CLR=0, WR_READY=0, FSM=IDLE, object count=0. Memory contents are not reset.
- Clear requirement: before first use, software or the bench must stream one full line of reads through each bank.
- Storage: two banks of LINE_W/SEG_W words. Each word holds SEG_W pixels, and each pixel is {opq, clr}.
- Write FSM states: IDLE, RD_A, WR_A, RD_B, WR_B.
- Address split: word A = WR_X/SEG_W; offset o = WR_X mod SEG_W.
- IDLE with WR_VALID=1: latch the request and go to RD_A. WR_READY pulses for 1 CE on this acceptance cycle only.
- RD_A: read word A. WR_A: merge and write word A.
- Merge rule per pixel: update where the mask bit is set and (PRIO_FIRST=0 or the stored opq=0). The written value is {1, WR_CLR}.
- Two-word segments: if o!=0, continue through RD_B/WR_B for word A+1 (modulo the line when WRAP=1). When WRAP=0 and A+1 is past the line, skip word B and return to IDLE.
- If o=0, return to IDLE after WR_A.
- Segment throughput: 2 CE aligned, 4 CE unaligned. With PRIO_FIRST=0 the RD states are skipped, giving 1 and 2 CE.
- Object limit: OBJ_START with WR_VALID increments the count at acceptance. When MAX_OBJ!=0 and the count is already MAX_OBJ, the segment is still handshaken but discarded. OVF is set and stays set until LINE_START.
- Read side: on RD_EN, PX_OPQ/PX_CLR present pixel RD_X of the front bank with 1 CE latency. Without RD_EN, the outputs hold.
- Clear-on-read: when RD_EN hits the last pixel of a word (RD_X mod SEG_W = SEG_W-1), that word is written to 0 in the same CE.
- Read/write separation: the read port and write port always target different banks, so there is no collision.
- LINE_START: BANK toggles, the object count and OVF clear, and the FSM returns to IDLE.
  - Any in-flight segment is aborted. Words already written stay; the pending word is not written.
  - WR_VALID on the same CE is not accepted.
- Simultaneous LINE_START and RD_EN: the read uses the pre-swap front bank.
- Widths: all X arithmetic is modulo LINE_W, and the count saturates at MAX_OBJ.

Test Plan:
- Aligned write: WR_X=16, PAT=8'hFF, CLR=5; then LINE_START and read X=16..23 -> PX_OPQ=1 and PX_CLR=5 for all 8; X=15 and X=24 read PX_OPQ=0; WR_READY high for 1 CE.
- Unaligned write: WR_X=13, PAT=8'b1000_0001, CLR=3 -> after the swap, X=13 and X=20 are opaque with colour 3; X=14..19 are transparent; FSM takes 4 CE.
- Priority:
  - PRIO_FIRST=1: CLR=2 then CLR=9 both at X=40 -> pixel colour 2.
  - PRIO_FIRST=0: same writes -> pixel colour 9.
- Overflow: MAX_OBJ=2, three objects at X=0, 8, 16 -> X=16 reads transparent; OVF=1 after the third OBJ_START; OVF=0 after LINE_START.
- Wrap: LINE_W=256, WR_X=252, PAT=8'hFF.
  - WRAP=1 -> X=252..255 and X=0..3 are opaque.
  - WRAP=0 -> only X=252..255 are opaque.
- Clear and reset:
  - Read a full line, swap twice, re-read -> all PX_OPQ=0.
  - RESB low mid-segment -> WR_READY=0, OVF=0, BANK=0 while reset is asserted; writes resume cleanly after release.

Source files
------------

// File: rtl/epochtv1_olb.sv
// epochtv1_olb: two-bank object line buffer for the TV-1 sprite path.
// The sprite drawer merges opaque pattern segments into the back bank through a
// small write FSM. The video side streams pixels out of the front bank and
// clears each word after its last pixel has been read.
module epochtv1_olb #(
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned CLR_W      = 4,
  parameter int unsigned MAX_OBJ    = 0,
  parameter int unsigned WRAP       = 0,
  parameter int unsigned PRIO_FIRST = 1
) (
  input  logic                      CLK,
  input  logic                      RESB,
  input  logic                      CE,
  input  logic                      LINE_START,
  input  logic                      OBJ_START,
  input  logic                      WR_VALID,
  output logic                      WR_READY,
  input  logic [$clog2(LINE_W)-1:0] WR_X,
  input  logic [SEG_W-1:0]          WR_PAT,
  input  logic [CLR_W-1:0]          WR_CLR,
  input  logic                      RD_EN,
  input  logic [$clog2(LINE_W)-1:0] RD_X,
  output logic                      PX_OPQ,
  output logic [CLR_W-1:0]          PX_CLR,
  output logic                      OVF,
  output logic                      BANK
);

  localparam int unsigned XW    = $clog2(LINE_W);
  localparam int unsigned OW    = $clog2(SEG_W);
  localparam int unsigned AW    = XW - OW;
  localparam int unsigned NWORD = LINE_W / SEG_W;
  localparam int unsigned PX_W  = CLR_W + 1;
  localparam int unsigned CNT_W = (MAX_OBJ == 0) ? 1 : $clog2(MAX_OBJ + 1);

  // One memory word: SEG_W pixels, index 0 is the leftmost, each {opq, clr}
  typedef logic [SEG_W-1:0][PX_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_WR_A = 3'd2,
    S_RD_B = 3'd3,
    S_WR_B = 3'd4
  } state_t;

  word_t              mem_q [2][NWORD];

  state_t             state_q, state_d;
  logic               bank_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               drop_q;
  logic               wr_ready_q;
  logic [XW-1:0]      seg_x_q;
  logic [SEG_W-1:0]   pat_q;
  logic [CLR_W-1:0]   clr_q;
  logic [SEG_W-1:0]   opq_rd_q;
  logic               px_opq_q;
  logic [CLR_W-1:0]   px_clr_q;

  logic [OW-1:0]      off_c;
  logic [AW-1:0]      addr_a_c;
  logic [AW-1:0]      addr_b_c;
  logic [AW-1:0]      addr_c;
  logic [2*SEG_W-1:0] ext_c;
  logic [SEG_W-1:0]   wmask_c;
  logic               we_c;
  logic [SEG_W-1:0]   pix_we_c;
  logic               accept_c;
  logic               limit_hit_c;
  logic               drop_new_c;
  logic               has_b_c;
  logic [AW-1:0]      rd_word_c;
  logic [OW-1:0]      rd_pix_c;
  logic               rd_last_c;
  logic [PX_W-1:0]    rd_px_c;

  // Segment geometry, acceptance and object-limit decode
  always_comb begin
    off_c       = seg_x_q[OW-1:0];
    addr_a_c    = seg_x_q[XW-1:OW];
    addr_b_c    = addr_a_c + AW'(1);
    ext_c       = {pat_q, SEG_W'(0)} >> off_c;
    accept_c    = CE && !LINE_START && WR_VALID && (state_q == S_IDLE);
    limit_hit_c = (MAX_OBJ != 0) && (cnt_q == CNT_W'(MAX_OBJ));
    drop_new_c  = OBJ_START ? limit_hit_c : drop_q;
    has_b_c     = (off_c != OW'(0)) && ((WRAP != 0) || (addr_a_c != AW'(NWORD - 1)));
    rd_word_c   = RD_X[XW-1:OW];
    rd_pix_c    = RD_X[OW-1:0];
    rd_last_c   = (rd_pix_c == OW'(SEG_W - 1));
    rd_px_c     = mem_q[~bank_q][rd_word_c][rd_pix_c];
  end

  // Write FSM next state plus word address, mask and write strobe
  always_comb begin
    state_d = state_q;
    we_c    = 1'b0;
    addr_c  = addr_a_c;
    wmask_c = ext_c[2*SEG_W-1:SEG_W];
    if (CE) begin
      case (state_q)
        S_IDLE: begin
          if (accept_c && !drop_new_c) begin
            state_d = (PRIO_FIRST != 0) ? S_RD_A : S_WR_A;
          end
        end
        S_RD_A: state_d = S_WR_A;
        S_WR_A: begin
          we_c = 1'b1;
          if (has_b_c) begin
            state_d = (PRIO_FIRST != 0) ? S_RD_B : S_WR_B;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RD_B: begin
          addr_c  = addr_b_c;
          wmask_c = ext_c[SEG_W-1:0];
          state_d = S_WR_B;
        end
        S_WR_B: begin
          we_c    = 1'b1;
          addr_c  = addr_b_c;
          wmask_c = ext_c[SEG_W-1:0];
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // A line swap aborts the segment; the pending word is never written
      if (LINE_START) begin
        state_d = S_IDLE;
        we_c    = 1'b0;
      end
    end
  end

  // Per-pixel merge: covered by the mask and not already claimed when first-wins
  always_comb begin
    pix_we_c = '0;
    for (int p = 0; p < int'(SEG_W); p++) begin
      pix_we_c[p] = we_c && wmask_c[int'(SEG_W) - 1 - p] &&
                    ((PRIO_FIRST == 0) || !opq_rd_q[p]);
    end
  end

  // Line memory: merged writes to the back bank, clear-on-read of the front bank
  always_ff @(posedge CLK) begin
    for (int p = 0; p < int'(SEG_W); p++) begin
      if (pix_we_c[p]) begin
        mem_q[bank_q][addr_c][p] <= {1'b1, clr_q};
      end
    end
    if (CE && RD_EN && rd_last_c) begin
      mem_q[~bank_q][rd_word_c] <= '0;
    end
  end

  // Write FSM state register
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, handshake pulse, object count, overflow and bank swap
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      bank_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      seg_x_q    <= '0;
      pat_q      <= '0;
      clr_q      <= '0;
    end else if (CE) begin
      wr_ready_q <= accept_c;
      if (accept_c) begin
        seg_x_q <= WR_X;
        pat_q   <= WR_PAT;
        clr_q   <= WR_CLR;
        drop_q  <= drop_new_c;
        if (OBJ_START && (MAX_OBJ != 0)) begin
          if (limit_hit_c) begin
            ovf_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
      if (LINE_START) begin
        bank_q <= ~bank_q;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        drop_q <= 1'b0;
      end
    end
  end

  // Opacity snapshot of the word being merged, taken in the read states
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      opq_rd_q <= '0;
    end else if (CE && ((state_q == S_RD_A) || (state_q == S_RD_B))) begin
      for (int p = 0; p < int'(SEG_W); p++) begin
        opq_rd_q[p] <= mem_q[bank_q][addr_c][p][PX_W-1];
      end
    end
  end

  // Pixel output register, one CE behind RD_EN; colour forced to 0 when transparent
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      px_opq_q <= 1'b0;
      px_clr_q <= '0;
    end else if (CE && RD_EN) begin
      px_opq_q <= rd_px_c[PX_W-1];
      px_clr_q <= rd_px_c[PX_W-1] ? rd_px_c[CLR_W-1:0] : CLR_W'(0);
    end
  end

  assign WR_READY = wr_ready_q;
  assign PX_OPQ   = px_opq_q;
  assign PX_CLR   = px_clr_q;
  assign OVF      = ovf_q;
  assign BANK     = bank_q;

endmodule

// File: tb/tb_epochtv1_olb.sv
// Bench for epochtv1_olb: two instances with contrasting configurations share
// one stimulus stream and are checked against a pixel-level line model.
module tb_epochtv1_olb;

  logic       CLK = 1'b0;
  logic       RESB;
  logic       CE = 1'b1;
  logic       LINE_START, OBJ_START, WR_VALID, RD_EN;
  logic [7:0] WR_X, RD_X, WR_PAT;
  logic [3:0] WR_CLR;

  logic       rdy_o  [2];
  logic       opq_o  [2];
  logic [3:0] clr_o  [2];
  logic       ovf_o  [2];
  logic       bank_o [2];

  // dut 0: first-wins, limit 2, wrap. dut 1: last-wins, unlimited, no wrap.
  int cfg_max  [2] = '{2, 0};
  int cfg_wrap [2] = '{1, 0};
  int cfg_prio [2] = '{1, 0};

  epochtv1_olb #(.LINE_W(256), .SEG_W(8), .CLR_W(4), .MAX_OBJ(2), .WRAP(1), .PRIO_FIRST(1)) u_a (
    .CLK(CLK), .RESB(RESB), .CE(CE), .LINE_START(LINE_START), .OBJ_START(OBJ_START),
    .WR_VALID(WR_VALID), .WR_READY(rdy_o[0]), .WR_X(WR_X), .WR_PAT(WR_PAT), .WR_CLR(WR_CLR),
    .RD_EN(RD_EN), .RD_X(RD_X), .PX_OPQ(opq_o[0]), .PX_CLR(clr_o[0]), .OVF(ovf_o[0]),
    .BANK(bank_o[0]));

  epochtv1_olb #(.LINE_W(256), .SEG_W(8), .CLR_W(4), .MAX_OBJ(0), .WRAP(0), .PRIO_FIRST(0)) u_b (
    .CLK(CLK), .RESB(RESB), .CE(CE), .LINE_START(LINE_START), .OBJ_START(OBJ_START),
    .WR_VALID(WR_VALID), .WR_READY(rdy_o[1]), .WR_X(WR_X), .WR_PAT(WR_PAT), .WR_CLR(WR_CLR),
    .RD_EN(RD_EN), .RD_X(RD_X), .PX_OPQ(opq_o[1]), .PX_CLR(clr_o[1]), .OVF(ovf_o[1]),
    .BANK(bank_o[1]));

  always #5 CLK = ~CLK;

  // Optional random CE throttling, changed away from the active edge
  bit ce_rand = 1'b0;
  always @(negedge CLK) CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain pixel arrays per instance and bank
  bit       mo [2][2][256];
  bit [3:0] mc [2][2][256];
  int       m_cnt  [2];
  bit       m_drop [2];
  bit       m_ovf  [2];
  bit       m_bank;

  typedef struct {
    bit       chk;
    int       x;
    bit       opq;
    bit [3:0] clr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(string nm, int d, logic [31:0] act, int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  task automatic m_write(int x, bit [7:0] pat, bit [3:0] c, bit obj);
    for (int d = 0; d < 2; d++) begin
      if (obj) begin
        if (cfg_max[d] != 0 && m_cnt[d] >= cfg_max[d]) begin
          m_drop[d] = 1'b1;
          m_ovf[d]  = 1'b1;
        end else begin
          m_drop[d] = 1'b0;
          m_cnt[d]++;
        end
      end
      if (!m_drop[d]) begin
        for (int i = 0; i < 8; i++) begin
          if (pat[7-i]) begin
            int xx;
            xx = x + i;
            if (xx >= 256 && cfg_wrap[d] == 0) continue;
            xx = xx % 256;
            if (cfg_prio[d] == 0 || !mo[d][m_bank][xx]) begin
              mo[d][m_bank][xx] = 1'b1;
              mc[d][m_bank][xx] = c;
            end
          end
        end
      end
    end
  endtask

  task automatic m_read(int x, bit chkit);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   fb;
      fb    = !m_bank;
      e.chk = chkit;
      e.x   = x;
      e.opq = mo[d][fb][x];
      e.clr = e.opq ? mc[d][fb][x] : 4'd0;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (x % 8 == 7) begin
        for (int k = x - 7; k <= x; k++) begin
          mo[d][fb][k] = 1'b0;
          mc[d][fb][k] = 4'd0;
        end
      end
    end
  endtask

  task automatic m_ls();
    m_bank = !m_bank;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_drop[d] = 1'b0;
      m_ovf[d]  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    while (!CE) @(posedge CLK);
    #1;
  endtask

  task automatic wr(int x, bit [7:0] pat, bit [3:0] c, bit obj);
    WR_VALID  = 1'b1;
    WR_X      = 8'(x);
    WR_PAT    = pat;
    WR_CLR    = c;
    OBJ_START = obj;
    m_write(x, pat, c, obj);
    tick();
    WR_VALID  = 1'b0;
    OBJ_START = 1'b0;
    for (int d = 0; d < 2; d++) chk("wr_ready_pulse", d, 32'(rdy_o[d]), 1);
    tick();
    for (int d = 0; d < 2; d++) chk("wr_ready_drop", d, 32'(rdy_o[d]), 0);
    repeat (4) tick();
  endtask

  task automatic line_start();
    LINE_START = 1'b1;
    m_ls();
    tick();
    LINE_START = 1'b0;
    for (int d = 0; d < 2; d++) chk("bank", d, 32'(bank_o[d]), int'(m_bank));
  endtask

  task automatic read_line(bit chkit, bit ls_last);
    for (int x = 0; x < 256; x++) begin
      RD_EN = 1'b1;
      RD_X  = 8'(x);
      LINE_START = ls_last && (x == 255);
      m_read(x, chkit);
      if (ls_last && x == 255) m_ls();
      tick();
      LINE_START = 1'b0;
    end
    RD_EN = 1'b0;
  endtask

  task automatic chk_ovf(string nm);
    for (int d = 0; d < 2; d++) chk(nm, d, 32'(ovf_o[d]), int'(m_ovf[d]));
  endtask

  task automatic clear_both();
    read_line(1'b0, 1'b0);
    line_start();
    read_line(1'b0, 1'b0);
    line_start();
  endtask

  // Monitor: every CE-qualified read produces one pixel one CE later
  always @(posedge CLK) begin
    if (RESB && CE && RD_EN) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        bit   empty;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          n_checks++;
          n_errors++;
          $display("FAIL px_unexpected dut%0d: output with no expected entry", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (e.chk) begin
            n_checks++;
            if ({opq_o[d], clr_o[d]} !== {e.opq, e.clr}) begin
              n_errors++;
              $display("FAIL px dut%0d x=%0d: got opq=%0b clr=%0d expected opq=%0b clr=%0d",
                       d, e.x, opq_o[d], clr_o[d], e.opq, e.clr);
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_ready"}, d, 32'(rdy_o[d]), 0);
      chk({nm, "_ovf"},   d, 32'(ovf_o[d]), 0);
      chk({nm, "_bank"},  d, 32'(bank_o[d]), 0);
      chk({nm, "_opq"},   d, 32'(opq_o[d]), 0);
      chk({nm, "_clr"},   d, 32'(clr_o[d]), 0);
    end
  endtask

  task automatic reset_model();
    m_bank = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_drop[d] = 1'b0;
      m_ovf[d]  = 1'b0;
    end
  endtask

  initial begin
    RESB = 1'b0; LINE_START = 1'b0; OBJ_START = 1'b0; WR_VALID = 1'b0; RD_EN = 1'b0;
    WR_X = '0; RD_X = '0; WR_PAT = '0; WR_CLR = '0;
    reset_model();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    @(negedge CLK);
    RESB = 1'b1;

    clear_both();

    // Aligned, unaligned, priority and wrap segments, each followed by a full read
    wr(16, 8'hFF, 4'd5, 1'b1);
    line_start();
    read_line(1'b1, 1'b0);

    wr(13, 8'b1000_0001, 4'd3, 1'b1);
    line_start();
    read_line(1'b1, 1'b0);

    wr(40, 8'hFF, 4'd2, 1'b1);
    wr(40, 8'hFF, 4'd9, 1'b1);
    line_start();
    read_line(1'b1, 1'b0);

    wr(0, 8'hFF, 4'd7, 1'b1);
    wr(8, 8'hFF, 4'd7, 1'b1);
    chk_ovf("ovf_at_limit");
    wr(16, 8'hFF, 4'd7, 1'b1);
    chk_ovf("ovf_over_limit");
    wr(24, 8'hF0, 4'd7, 1'b0);
    line_start();
    chk_ovf("ovf_after_swap");
    read_line(1'b1, 1'b0);

    wr(252, 8'hFF, 4'd6, 1'b1);
    line_start();
    read_line(1'b1, 1'b1);

    // Request coinciding with a line swap is not accepted
    WR_VALID = 1'b1; WR_X = 8'd64; WR_PAT = 8'hFF; WR_CLR = 4'd1; OBJ_START = 1'b1;
    LINE_START = 1'b1;
    m_ls();
    tick();
    WR_VALID = 1'b0; LINE_START = 1'b0; OBJ_START = 1'b0;
    for (int d = 0; d < 2; d++) chk("ready_on_swap", d, 32'(rdy_o[d]), 0);
    tick();
    for (int d = 0; d < 2; d++) chk("ready_after_swap", d, 32'(rdy_o[d]), 0);
    read_line(1'b1, 1'b0);

    // Already-read line stays empty across two swaps
    line_start();
    line_start();
    read_line(1'b1, 1'b0);

    // Randomized segments with throttled CE
    ce_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int nseg;
      nseg = $urandom_range(1, 6);
      for (int s = 0; s < nseg; s++) begin
        int x;
        x = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) x = x & 248;
        wr(x, 8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)),
           (s == 0) || ($urandom_range(0, 1) == 1));
        chk_ovf("ovf_rand");
      end
      line_start();
      read_line(1'b1, 1'($urandom_range(0, 1)));
    end
    ce_rand = 1'b0;

    // Reset while a segment is in flight, with BANK=1 and OVF=1 beforehand
    if (!m_bank) line_start();
    wr(0, 8'hFF, 4'd1, 1'b1);
    wr(8, 8'hFF, 4'd1, 1'b1);
    wr(16, 8'hFF, 4'd1, 1'b1);
    chk_ovf("ovf_pre_reset");
    WR_VALID = 1'b1; WR_X = 8'd37; WR_PAT = 8'hFF; WR_CLR = 4'd2; OBJ_START = 1'b1;
    tick();
    WR_VALID = 1'b0; OBJ_START = 1'b0;
    #2;
    RESB = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("held_reset");
    @(negedge CLK);
    RESB = 1'b1;
    reset_model();
    clear_both();

    wr(100, 8'hA5, 4'd11, 1'b1);
    wr(201, 8'h3C, 4'd4, 1'b1);
    line_start();
    read_line(1'b1, 1'b0);

    // Drain the scoreboard within a bounded window
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
